instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch stage directly upstream of the control unit: owns the PC, issues word reads to instruction
//  memory over a req/valid interface, holds the returned instruction and presents its 4-bit opcode
//  and fields to decode. Redirects to a branch target on flush from execute.
//  One outstanding memory read at a time.
// PARAMETERS
//  ADDR_W   8   PC / instruction-memory word-address width
//  INSTR_W  16  instruction width; opcode = instr[INSTR_W-1 -: 4]
// PORTS
//  clk            in   1        single clock, rising edge
//  rst            in   1        synchronous, active-high reset
//  imem_req       out  1        one-cycle read request, address = imem_addr
//  imem_addr      out  ADDR_W   word address of request (= pc)
//  imem_valid     in   1        read data valid; 1..N cycles after imem_req, exactly once per req
//  imem_rdata     in   INSTR_W  instruction word, sampled when imem_valid=1
//  instr_valid    out  1        instr/opcode/instr_pc hold a live instruction
//  instr_ready    in   1        decode consumes the instruction this cycle
//  instr          out  INSTR_W  held instruction word
//  opcode         out  4        instr[INSTR_W-1 -: 4], to control unit
//  instr_pc       out  ADDR_W   address the held instruction was fetched from
//  flush          in   1        branch taken in execute: discard held/in-flight instruction
//  flush_target   in   ADDR_W   new PC, sampled when flush=1
// BEHAVIOUR
//  - Reset (sync, rst=1 at edge): state=REQ, pc=0, instr=0, instr_pc=0, instr_valid=0;
//    imem_req=0 while rst=1. rst mid-transaction abandons it; a late imem_valid is dropped (DRAIN-like
//    ignore is NOT required: memory is reset by the same rst).
//  - imem_req = (state==REQ); imem_addr = pc. All other outputs registered.
//  - States and transitions (flush has priority over every other event):
//    REQ   : req issued this cycle -> WAIT. flush: pc<=flush_target, ->DRAIN (issued req is in flight).
//    WAIT  : imem_valid & !flush: instr<=imem_rdata, instr_pc<=pc, pc<=pc+1, instr_valid<=1 -> HOLD.
//            flush & !imem_valid: pc<=flush_target -> DRAIN.
//            flush & imem_valid: data discarded, pc<=flush_target -> REQ.
//    HOLD  : instr_ready & !flush: instr_valid<=0 -> REQ. flush: instr_valid<=0, pc<=flush_target -> REQ
//            (flush wins over same-cycle instr_ready; instruction counts as not consumed).
//    DRAIN : wait for stale imem_valid, discard -> REQ. flush: pc<=flush_target, stay DRAIN.
//  - instr/opcode/instr_pc stable while instr_valid=1; unchanged (stale) when instr_valid=0.
//  - pc+1 is modulo 2^ADDR_W: pc=2^ADDR_W-1 wraps to 0, no flag.
//  - Latency: REQ to instr_valid = 1 + memory latency cycles; minimum 3 cycles per instruction with
//    1-cycle memory and instr_ready tied high.
//  - Back-pressure: instr_ready=0 holds HOLD indefinitely; no new req issued.
//  - imem_valid outside WAIT/DRAIN is a protocol error: ignored, assertion flags it.
// STRUCTURE
//  - cpu_pkg: fetch_state_t enum {REQ, WAIT, HOLD, DRAIN}; OPC_W=4; OPC_BRANCH=4'b0111;
//    instruction field positions (opcode [15:12], rd [11:8], rs [7:4], rt/imm [3:0]).
//  - Sub-module fetch_pc_reg: PC register with sync reset, load (flush_target) and increment (wrap).
//  - FSM and instruction register in instr_fetch itself.
// TESTING
//  1 Reset then 1-cycle memory returning 16'h1234 at addr 0, ready=1 -> imem_req at cycle 1 addr 0;
//    instr_valid with instr=16'h1234, opcode=4'h1, instr_pc=0; next req addr 1.
//  2 Memory latency 4, ready=0 for 5 cycles after valid -> instr_valid held, instr stable, no imem_req
//    until ready=1; then req at addr 1.
//  3 flush (target 8'h40) in WAIT before data -> DRAIN; stale data 16'h7FFF dropped, instr_valid
//    stays 0; next req addr 8'h40.
//  4 flush (target 8'h10) same cycle as imem_valid in WAIT, and separately in HOLD with instr_ready=1
//    -> data discarded, instr_valid=0, next req addr 8'h10.
//  5 pc preloaded to 8'hFF via flush, fetch completes -> instr_pc=8'hFF, next req addr 8'h00.
//  6 rst asserted in HOLD with instr_valid=1 -> next cycle instr_valid=0, instr=0, then req addr 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end.
// Contents:
//   fetch_state_t : fetch FSM states {REQ, WAIT, HOLD, DRAIN}
//   OPC_W         : opcode width
//   OPC_BRANCH    : branch opcode value
//   field positions for the 16-bit instruction format
//   is_branch()   : opcode classification helper
package cpu_pkg;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int OPC_W = 4;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 4'b0111;

    // Instruction field positions: opcode | rd | rs | rt/imm
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 7;
    localparam int RS_LSB  = 4;
    localparam int RT_MSB  = 3;
    localparam int RT_LSB  = 0;

    function automatic logic is_branch(input logic [OPC_W-1:0] opc);
        return (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register for the fetch stage.
// Ports:
//   clk_i, rst_i : clock and synchronous active-high reset (pc -> 0)
//   load_i       : load load_addr_i (redirect); has priority over inc_i
//   load_addr_i  : redirect target
//   inc_i        : advance to next word address, wrapping modulo 2^ADDR_W
//   pc_o         : current pc
module fetch_pc_reg #(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next-pc selection: redirect beats increment; increment wraps naturally
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_addr_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_checker.sv
// Protocol checker for the fetch stage memory interface.
// Ports:
//   clk, rst   : clock and synchronous reset
//   imem_valid : read-data valid from instruction memory
//   state_i    : current fetch FSM state
// Flags read data arriving when no read can be outstanding.
module instr_fetch_checker
    import cpu_pkg::*;
(
    input logic         clk,
    input logic         rst,
    input logic         imem_valid,
    input fetch_state_t state_i
);

    a_valid_only_when_outstanding: assert property (
        @(posedge clk) disable iff (rst)
        imem_valid |-> (state_i == WAIT || state_i == DRAIN)
    );

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Owns the PC, issues one word read at a time to instruction memory,
// holds the returned instruction for decode and redirects on flush.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   imem_req / imem_addr  : one-cycle read request at pc
//   imem_valid/imem_rdata : read return, exactly once per request
//   instr_valid/instr_ready : handshake to decode
//   instr, opcode, instr_pc : held instruction, its opcode and fetch address
//   flush / flush_target  : redirect from execute (highest priority)
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_target
);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0]  pc_s;
    logic               pc_inc_s;

    fetch_pc_reg #(.ADDR_W(ADDR_W)) u_pc (
        .clk_i       (clk),
        .rst_i       (rst),
        .load_i      (flush),
        .load_addr_i (flush_target),
        .inc_i       (pc_inc_s),
        .pc_o        (pc_s)
    );

    // Fetch FSM next state and instruction register update
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        pc_inc_s      = 1'b0;
        case (state_q)
            REQ: begin
                // The request goes out this cycle regardless; a flush leaves it in flight
                if (flush) begin
                    state_d = DRAIN;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = imem_valid ? REQ : DRAIN;
                end else if (imem_valid) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_s;
                    instr_valid_d = 1'b1;
                    pc_inc_s      = 1'b1;
                    state_d       = HOLD;
                end else begin
                    state_d = WAIT;
                end
            end
            HOLD: begin
                // Flush wins over a same-cycle consume
                if (flush || instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end else begin
                    state_d = HOLD;
                end
            end
            DRAIN: begin
                // A stale return arriving with a new flush still retires the
                // outstanding read, so waiting longer would deadlock
                if (imem_valid) begin
                    state_d = REQ;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d       = REQ;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // FSM and instruction holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= REQ;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = (state_q == REQ) && !rst;
    assign imem_addr   = pc_s;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[INSTR_W-1 -: OPC_W];
    assign instr_pc    = instr_pc_q;

    instr_fetch_checker u_chk (
        .clk        (clk),
        .rst        (rst),
        .imem_valid (imem_valid),
        .state_i    (state_q)
    );

endmodule
